// File: rtl/keypad_debounce10.sv
// Decimal keypad front end: synchronizes ten raw key lines, debounces a single key press,
// holds it under a valid/ready handshake and waits for a debounced release before re-arming.
module keypad_debounce10 #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_in,
  input  logic       key_ready,
  output logic [9:0] key_onehot,
  output logic       key_valid,
  output logic       busy,
  output logic       multi_err
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  function automatic logic is_multi(input logic [9:0] v);
    return (v & (v - 10'd1)) != 10'd0;
  endfunction

  function automatic logic is_onehot(input logic [9:0] v);
    return (v != 10'd0) && !is_multi(v);
  endfunction

  // Saturating increment keeps a stuck input from wrapping the counter back into range.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic [9:0]    sync1_q, key_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [9:0]    cand_q, cand_d;
  logic [9:0]    onehot_q, onehot_d;
  logic          valid_q, valid_d;
  logic          busy_q, multi_q;

  // Next-state and output decisions for the debounce/handshake FSM.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    cand_d   = cand_q;
    onehot_d = onehot_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(key_s_q)) begin
          cand_d  = key_s_q;
          count_d = CNT_ONE;
          state_d = ST_DEBOUNCE;
        end else begin
          count_d = CNT_ZERO;
        end
      end
      ST_DEBOUNCE: begin
        if (key_s_q == cand_q) begin
          count_d = cnt_inc(count_q);
          if (count_q == CNT_LAST) begin
            onehot_d = cand_q;
            valid_d  = 1'b1;
            state_d  = ST_HELD;
          end else begin
            state_d  = ST_DEBOUNCE;
          end
        end else begin
          count_d = CNT_ZERO;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        // Input activity is deliberately ignored here; only the handshake moves us on.
        if (key_ready) begin
          valid_d = 1'b0;
          count_d = CNT_ZERO;
          state_d = ST_RELEASE;
        end else begin
          valid_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (key_s_q == 10'd0) begin
          if (count_q == CNT_LAST) begin
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
          end else begin
            count_d = cnt_inc(count_q);
          end
        end else begin
          count_d = CNT_ZERO;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
        valid_d = 1'b0;
      end
    endcase
  end

  // Synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 10'd0;
      key_s_q  <= 10'd0;
      state_q  <= ST_IDLE;
      count_q  <= CNT_ZERO;
      cand_q   <= 10'd0;
      onehot_q <= 10'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      sync1_q  <= key_in;
      key_s_q  <= sync1_q;
      state_q  <= state_d;
      count_q  <= count_d;
      cand_q   <= cand_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != ST_IDLE);
      multi_q  <= is_multi(key_s_q);
    end
  end

  assign key_onehot = onehot_q;
  assign key_valid  = valid_q;
  assign busy       = busy_q;
  assign multi_err  = multi_q;

endmodule
